// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing defaults, derived totals and sync windows, colour-bar palette.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a; the raster is free-running and never stalls.
package vga_pkg;

    // Default 640x480@60 timing, in pixels (horizontal) and whole lines (vertical).
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CNT_W    = 10;

    // Colour bus is {R[3:0],G[3:0],B[3:0]} straight into the resistor DAC.
    localparam int RGB_W = 12;
    typedef logic [RGB_W-1:0] rgb_t;

    // Sync pulse starts right after the front porch and lasts the sync width.
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync - 1;
    endfunction

    function automatic int total_len(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL      = total_len(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL      = total_len(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
    localparam int VGA_H_SYNC_START = sync_start(VGA_H_ACTIVE, VGA_H_FP);
    localparam int VGA_H_SYNC_END   = sync_end(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC);
    localparam int VGA_V_SYNC_START = sync_start(VGA_V_ACTIVE, VGA_V_FP);
    localparam int VGA_V_SYNC_END   = sync_end(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC);

    // Test-pattern geometry: eight equal-width vertical bars across the active line.
    localparam int BAR_COUNT = 8;
    localparam int BAR_W     = VGA_H_ACTIVE / BAR_COUNT;

    localparam rgb_t COL_WHITE   = 12'hFFF;
    localparam rgb_t COL_YELLOW  = 12'hFF0;
    localparam rgb_t COL_CYAN    = 12'h0FF;
    localparam rgb_t COL_GREEN   = 12'h0F0;
    localparam rgb_t COL_MAGENTA = 12'hF0F;
    localparam rgb_t COL_RED     = 12'hF00;
    localparam rgb_t COL_BLUE    = 12'h00F;
    localparam rgb_t COL_BLACK   = 12'h000;

    // Classic SMPTE-like ordering, left to right.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_counter.sv
// vga_counter: free-running horizontal/vertical raster counters with line-end and frame-end strobes.
// Latency: strobes are combinational from the current count; counts advance every clock.
// Backpressure: none; the raster never stalls, it only restarts on reset.
module vga_counter
    import vga_pkg::*;
#(
    parameter int H_TOTAL = VGA_H_TOTAL,
    parameter int V_TOTAL = VGA_V_TOTAL,
    parameter int CNT_W   = VGA_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [CNT_W-1:0] o_hcnt,
    output logic [CNT_W-1:0] o_vcnt,
    output logic             o_line_end,
    output logic             o_frame_end
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic             w_line_end;
    logic             w_frame_end;

    // Last pixel of a line, and last pixel of the last line of the frame.
    always_comb begin
        w_line_end  = (r_hcnt == H_LAST);
        w_frame_end = w_line_end && (r_vcnt == V_LAST);
    end

    // Pixel counter wraps every line; line counter steps (and wraps) on that same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_hcnt <= w_line_end ? '0 : r_hcnt + 1'b1;
            if (w_line_end) begin
                r_vcnt <= w_frame_end ? '0 : r_vcnt + 1'b1;
            end
        end
    end

    assign o_hcnt      = r_hcnt;
    assign o_vcnt      = r_vcnt;
    assign o_line_end  = w_line_end;
    assign o_frame_end = w_frame_end;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing, renderer coordinate bus and registered sync/RGB pins.
// Latency: coordinates 1 clock after the counters; HS/VS/RGB 2 clocks after, mutually aligned.
// Backpressure: none; renderer must answer PIX_RGB combinationally in the same cycle.
// Build option: define VGA_TEST_PATTERN_EN to replace PIX_RGB with eight vertical colour bars.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int CNT_W    = VGA_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [CNT_W-1:0] PIX_X,
    output logic [CNT_W-1:0] PIX_Y,
    output logic             PIX_DE,
    output logic             FRAME_START,
    input  logic [RGB_W-1:0] PIX_RGB,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic [RGB_W-1:0] VGA_RGB
);

    localparam int H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    logic             w_line_end;
    logic             w_frame_end;

    vga_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .CNT_W   (CNT_W)
    ) u_counter (
        .i_clk       (CLK),
        .i_rst_n     (RST),
        .o_hcnt      (w_hcnt),
        .o_vcnt      (w_vcnt),
        .o_line_end  (w_line_end),
        .o_frame_end (w_frame_end)
    );

    // ------------------------------------------------------------------
    // Stage 1: decode counters into active-video, frame marker and raw syncs
    // ------------------------------------------------------------------
    logic w_de;
    logic w_fs;
    logic w_hs;
    logic w_vs;

    // Sync windows are inclusive ranges; both syncs are active low.
    always_comb begin
        w_de = (w_hcnt < H_ACT_C) && (w_vcnt < V_ACT_C);
        w_fs = (w_hcnt == '0) && (w_vcnt == '0);
        w_hs = !((w_hcnt >= HS_START_C) && (w_hcnt <= HS_END_C));
        w_vs = !((w_vcnt >= VS_START_C) && (w_vcnt <= VS_END_C));
    end

    logic [CNT_W-1:0] r_pix_x;
    logic [CNT_W-1:0] r_pix_y;
    logic             r_pix_de;
    logic             r_frame_start;
    logic             r_hs1;
    logic             r_vs1;

    // Register coordinates (zeroed in blanking so the renderer sees a clean bus) and raw syncs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_de      <= 1'b0;
            r_frame_start <= 1'b0;
            r_hs1         <= 1'b1;
            r_vs1         <= 1'b1;
        end else begin
            r_pix_x       <= w_de ? w_hcnt : '0;
            r_pix_y       <= w_de ? w_vcnt : '0;
            r_pix_de      <= w_de;
            r_frame_start <= w_fs;
            r_hs1         <= w_hs;
            r_vs1         <= w_vs;
        end
    end

    // ------------------------------------------------------------------
    // Colour source: renderer pass-through or built-in bars
    // ------------------------------------------------------------------
    rgb_t w_rgb_src;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar_idx;
    logic       w_unused_pix_rgb;

    // Pick the leftmost bar whose right edge lies beyond the current column.
    always_comb begin
        w_bar_idx = 3'(BAR_COUNT - 1);
        for (int i = BAR_COUNT - 2; i >= 0; i--) begin
            if (r_pix_x < CNT_W'((i + 1) * BAR_W)) begin
                w_bar_idx = 3'(i);
            end
        end
    end

    assign w_rgb_src        = bar_colour(w_bar_idx);
    assign w_unused_pix_rgb = ^PIX_RGB;
`else
    assign w_rgb_src = PIX_RGB;
`endif

    // ------------------------------------------------------------------
    // Stage 2: pin registers, syncs and colour leave together
    // ------------------------------------------------------------------
    logic       r_vga_hs;
    logic       r_vga_vs;
    rgb_t       r_vga_rgb;

    // Blanking forces black so the DAC never sees colour during porches or sync.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_vga_hs  <= 1'b1;
            r_vga_vs  <= 1'b1;
            r_vga_rgb <= '0;
        end else begin
            r_vga_hs  <= r_hs1;
            r_vga_vs  <= r_vs1;
            r_vga_rgb <= r_pix_de ? w_rgb_src : '0;
        end
    end

    assign PIX_X       = r_pix_x;
    assign PIX_Y       = r_pix_y;
    assign PIX_DE      = r_pix_de;
    assign FRAME_START = r_frame_start;
    assign VGA_HS      = r_vga_hs;
    assign VGA_VS      = r_vga_vs;
    assign VGA_RGB     = r_vga_rgb;

    // ------------------------------------------------------------------
    // Structural invariants of the raster counter
    // ------------------------------------------------------------------
    a_line_wrap: assert property (@(posedge CLK) disable iff (!RST)
        w_line_end |=> (w_hcnt == '0));

    a_frame_wrap: assert property (@(posedge CLK) disable iff (!RST)
        w_frame_end |=> ((w_hcnt == '0) && (w_vcnt == '0)));

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench; driver pushes expected pins per clock, monitor pops and compares.
// Vertical timing is shortened so that several whole frames fit in a short run.
module tb_vga_sync_gen;

    localparam int HA = 640, HFP = 16, HSY = 96, HBP = 48;
    localparam int VA = 8,   VFP = 2,  VSY = 2,  VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int HSS = HA + HFP;
    localparam int VSS = VA + VFP;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [11:0] PIX_RGB = 12'h000;
    logic [9:0]  PIX_X, PIX_Y;
    logic        PIX_DE, FRAME_START, VGA_HS, VGA_VS;
    logic [11:0] VGA_RGB;

    vga_sync_gen #(
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PIX_X       (PIX_X),
        .PIX_Y       (PIX_Y),
        .PIX_DE      (PIX_DE),
        .FRAME_START (FRAME_START),
        .PIX_RGB     (PIX_RGB),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_RGB     (VGA_RGB)
    );

    always #20 CLK = ~CLK;

    typedef struct {
        int k;
        int x, y, de, fs, hs, vs, rgb;
    } exp_t;

    exp_t sb_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int k        = 0;
    bit run      = 1'b0;
    int rgb_mode = 0;
    logic [11:0] rgb_fix = 12'h000;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, k);
        end
    endtask

    // Colour the pins should carry for active column x when the renderer returned r.
    function automatic int colour_for(input int x, input int r);
`ifdef VGA_TEST_PATTERN_EN
        case (x / 80)
            0: return 'hFFF;
            1: return 'hFF0;
            2: return 'h0FF;
            3: return 'h0F0;
            4: return 'hF0F;
            5: return 'hF00;
            6: return 'h00F;
            default: return 'h000 + (r & 0);
        endcase
`else
        return r;
`endif
    endfunction

    // Driver: before edge k, drive the renderer colour and predict pins after edge k.
    exp_t        d_e;
    int          p1, x1, y1, p2, x2, y2;
    logic [11:0] drv_rgb;
    initial forever begin
        @(negedge CLK);
        if (run) begin
            k++;
            drv_rgb = (rgb_mode != 0) ? rgb_fix : 12'($urandom);
            PIX_RGB = drv_rgb;
            p1 = k - 1;
            x1 = p1 % HT;
            y1 = (p1 / HT) % VT;
            d_e.k  = k;
            d_e.de = (x1 < HA && y1 < VA) ? 1 : 0;
            d_e.x  = (d_e.de != 0) ? x1 : 0;
            d_e.y  = (d_e.de != 0) ? y1 : 0;
            d_e.fs = (p1 % FRAME == 0) ? 1 : 0;
            if (k == 1) begin
                d_e.hs = 1; d_e.vs = 1; d_e.rgb = 0;
            end else begin
                p2 = k - 2;
                x2 = p2 % HT;
                y2 = (p2 / HT) % VT;
                d_e.hs  = (x2 >= HSS && x2 < HSS + HSY) ? 0 : 1;
                d_e.vs  = (y2 >= VSS && y2 < VSS + VSY) ? 0 : 1;
                d_e.rgb = (x2 < HA && y2 < VA) ? colour_for(x2, int'(drv_rgb)) : 0;
            end
            sb_q.push_back(d_e);
        end
    end

    // Monitor: compare every presented cycle and measure pulse widths and periods.
    exp_t m_e;
    bit   prev_hs, prev_de, prev_vs, hs_first;
    int   hs_fall_k, de_rise_k, last_fs_k, vs_low, fs_periods = 0, seen_123 = 0;
    initial forever begin
        @(posedge CLK);
        #1;
        if (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            check("pix_x",       32'(PIX_X),       m_e.x);
            check("pix_y",       32'(PIX_Y),       m_e.y);
            check("pix_de",      32'(PIX_DE),      m_e.de);
            check("frame_start", 32'(FRAME_START), m_e.fs);
            check("vga_hs",      32'(VGA_HS),      m_e.hs);
            check("vga_vs",      32'(VGA_VS),      m_e.vs);
            check("vga_rgb",     32'(VGA_RGB),     m_e.rgb);
            if (m_e.k == 1) begin
                prev_hs = 1'b1; prev_de = 1'b0; prev_vs = 1'b1;
                hs_first = 1'b1; last_fs_k = 0; vs_low = 0;
            end
            if (prev_hs && !VGA_HS) begin
                if (hs_first) begin
                    check("hs_first_fall", m_e.k, HSS + 2);
                    hs_first = 1'b0;
                end
                hs_fall_k = m_e.k;
            end
            if (!prev_hs && VGA_HS) check("hs_low_len", m_e.k - hs_fall_k, HSY);
            if (!prev_de && PIX_DE) de_rise_k = m_e.k;
            if (prev_de && !PIX_DE) check("de_len", m_e.k - de_rise_k, HA);
            if (FRAME_START) begin
                if (last_fs_k != 0) begin
                    check("fs_period", m_e.k - last_fs_k, FRAME);
                    fs_periods++;
                end
                last_fs_k = m_e.k;
            end
            if (!VGA_VS) vs_low++;
            if (!prev_vs && VGA_VS) begin
                check("vs_low_cycles", vs_low, VSY * HT);
                vs_low = 0;
            end
            if (VGA_RGB == 12'h123) seen_123++;
            prev_hs = VGA_HS;
            prev_de = PIX_DE;
            prev_vs = VGA_VS;
        end
    end

    // Wait (bounded) until the coordinate bus shows active column tx.
    task automatic wait_pix(input int tx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge CLK);
            #2;
            if (PIX_DE && int'(PIX_X) == tx) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"},   32'(PIX_X),       0);
        check({tag, "_y"},   32'(PIX_Y),       0);
        check({tag, "_de"},  32'(PIX_DE),      0);
        check({tag, "_fs"},  32'(FRAME_START), 0);
        check({tag, "_hs"},  32'(VGA_HS),      1);
        check({tag, "_vs"},  32'(VGA_VS),      1);
        check({tag, "_rgb"}, 32'(VGA_RGB),     0);
    endtask

    int tgt_x   [3] = '{0, 80, 600};
`ifdef VGA_TEST_PATTERN_EN
    int tgt_rgb [3] = '{'hFFF, 'hFF0, 'h000};
`else
    int tgt_rgb [3] = '{'h123, 'h123, 'h123};
`endif

    initial begin
        bit ok;
        repeat (3) @(posedge CLK);
        #2;
        check_reset_vals("rst");

        // Release with a fixed renderer colour.
        rgb_fix  = 12'hABC;
        rgb_mode = 1;
        k        = 0;
        RST      = 1'b1;
        run      = 1'b1;
        @(posedge CLK); #2;
        check("rel1_de", 32'(PIX_DE), 1);
        check("rel1_fs", 32'(FRAME_START), 1);
        check("rel1_x",  32'(PIX_X), 0);
        check("rel1_y",  32'(PIX_Y), 0);
        @(posedge CLK); #2;
        check("rel2_rgb", 32'(VGA_RGB), colour_for(0, 'hABC));
        check("rel2_hs",  32'(VGA_HS), 1);
        check("rel2_vs",  32'(VGA_VS), 1);

        // End-of-line boundary with full white from the renderer.
        rgb_fix = 12'hFFF;
        wait_pix(639, ok);
        check("wait_x639", 32'(ok), 1);
        @(posedge CLK); #2;
        check("edge_rgb_639", 32'(VGA_RGB), colour_for(639, 'hFFF));
        check("edge_x_blank", 32'(PIX_X), 0);
        check("edge_de_blank", 32'(PIX_DE), 0);
        @(posedge CLK); #2;
        check("blank_rgb", 32'(VGA_RGB), 0);

        // Specific columns with a distinctive renderer colour.
        rgb_fix = 12'h123;
        for (int i = 0; i < 3; i++) begin
            wait_pix(tgt_x[i], ok);
            check("wait_tgt", 32'(ok), 1);
            @(posedge CLK); #2;
            check("tgt_rgb", 32'(VGA_RGB), tgt_rgb[i]);
        end

        // Random colours across two whole frames.
        rgb_mode = 0;
        repeat (2 * FRAME + 500) @(posedge CLK);
        check("fs_periods_seen", 32'(fs_periods >= 2), 1);

        // Asynchronous reset in the middle of a horizontal sync pulse.
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge CLK); #2;
            if (k % HT == 700) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_h700", 32'(ok), 1);
        check("pre_rst_hs", 32'(VGA_HS), 0);
        #5;
        run = 1'b0;
        RST = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat (2) @(posedge CLK);
        #2;
        check_reset_vals("held_rst");

        // Restart: frame must begin again at (0,0).
        k   = 0;
        RST = 1'b1;
        run = 1'b1;
        @(posedge CLK); #2;
        check("restart_de", 32'(PIX_DE), 1);
        check("restart_fs", 32'(FRAME_START), 1);
        check("restart_x",  32'(PIX_X), 0);
        check("restart_y",  32'(PIX_Y), 0);
        repeat (1500) @(posedge CLK);

        run = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        check("sb_drained", 32'(sb_q.size()), 0);
`ifdef VGA_TEST_PATTERN_EN
        check("rgb_123_seen", 32'(seen_123), 0);
`else
        check("rgb_123_seen", 32'(seen_123 > 0), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
